// File: rtl/svc_pkg.sv
// Shared service codes and arbiter state encoding for the service display arbiter.
package svc_pkg;

  localparam logic [3:0] SVC1     = 4'b1000;
  localparam logic [3:0] SVC2     = 4'b0100;
  localparam logic [3:0] SVC3     = 4'b0010;
  localparam logic [3:0] SVC4     = 4'b0001;
  localparam logic [3:0] SVC_NONE = 4'b0000;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE     = 3'd0;
  localparam arb_state_t ST_OWN      = 3'd1;
  localparam arb_state_t ST_DONE     = 3'd2;
  localparam arb_state_t ST_CONFLICT = 3'd3;
  localparam arb_state_t ST_PREEMPT  = 3'd4;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/service_display_arbiter_digit_scan.sv
// Time-multiplexed 4-digit scan with blink masking; anode and digit are registered.
module digit_scan #(
  parameter int unsigned SCAN_W  = 16,
  parameter int unsigned BLINK_W = 25
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic        i_active,
  input  logic [15:0] i_word,
  input  logic [3:0]  i_mask,
  input  logic        i_blink_en,
  output logic [3:0]  o_anode,
  output logic [3:0]  o_digit
);

  logic [SCAN_W-1:0]  r_cnt;
  logic [BLINK_W-1:0] r_bcnt;
  logic [3:0]         r_anode;
  logic [3:0]         r_digit;
  logic [1:0]         w_idx;
  logic               w_phase;
  logic               w_hide;
  logic [3:0]         w_nibble;

  assign w_idx   = r_cnt[SCAN_W-1 -: 2];
  assign w_phase = r_bcnt[BLINK_W-1];
  // Masked digit is hidden only during the invisible half of the blink period.
  assign w_hide  = i_blink_en & i_mask[w_idx] & ~w_phase;

  always_comb begin
    w_nibble = '0;
    case (w_idx)
      2'd0: w_nibble = i_word[3:0];
      2'd1: w_nibble = i_word[7:4];
      2'd2: w_nibble = i_word[11:8];
      2'd3: w_nibble = i_word[15:12];
      default: w_nibble = '0;
    endcase
  end

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_anode <= '1;
      r_digit <= '0;
    end else begin
      r_cnt  <= r_cnt + SCAN_W'(1);
      r_bcnt <= r_bcnt + BLINK_W'(1);
      if (!i_active || w_hide) begin
        r_anode <= '1;
      end else begin
        r_anode <= ~(4'b0001 << w_idx);
      end
      r_digit <= i_active ? w_nibble : '0;
    end
  end

  assign o_anode = r_anode;
  assign o_digit = r_digit;

endmodule

// File: rtl/service_display_arbiter.sv
// Arbitrates display/LED ownership among four services and drives the digit scan.
// Optional alarm preemption is built when ALARM_PREEMPT_EN is defined.
module service_display_arbiter
  import svc_pkg::*;
#(
  parameter int unsigned SCAN_W   = 16,
  parameter int unsigned BLINK_W  = 25,
  parameter int unsigned STABLE_N = 4
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  finish,
  input  logic        alarm_ring,
  input  logic [63:0] num_bus,
  input  logic [7:0]  blink_mask,
  output logic [3:0]  grant,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic [3:0]  mode_led,
  output logic        conflict
);

  localparam int unsigned FILT_W = $clog2(STABLE_N + 1);

  logic [3:0]        r_req_s1;
  logic [3:0]        r_req_s2;
  logic [3:0]        r_req_cand;
  logic [3:0]        r_reqf;
  logic [FILT_W-1:0] r_stab_cnt;
  logic [FILT_W-1:0] w_stab_nx;

  arb_state_t        r_state;
  arb_state_t        w_state_nx;
  logic [3:0]        r_grant;
  logic [3:0]        w_grant_nx;
  logic [2:0]        w_pop;

  logic [15:0]       w_word;
  logic [3:0]        w_mask;
  logic              w_blink_en;

  // w_stab_nx counts identical synced samples including the current one.
  always_comb begin
    if (r_req_s2 != r_req_cand) begin
      w_stab_nx = FILT_W'(1);
    end else if (r_stab_cnt >= FILT_W'(STABLE_N)) begin
      w_stab_nx = r_stab_cnt;
    end else begin
      w_stab_nx = r_stab_cnt + FILT_W'(1);
    end
  end

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_req_s1   <= '0;
      r_req_s2   <= '0;
      r_req_cand <= '0;
      r_stab_cnt <= '0;
      r_reqf     <= '0;
    end else begin
      r_req_s1   <= req;
      r_req_s2   <= r_req_s1;
      r_req_cand <= r_req_s2;
      r_stab_cnt <= w_stab_nx;
      if (w_stab_nx >= FILT_W'(STABLE_N)) begin
        r_reqf <= r_req_s2;
      end
    end
  end

  assign w_pop = popcount4(r_reqf);

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_pop > 3'd1) begin
          w_state_nx = ST_CONFLICT;
          w_grant_nx = SVC_NONE;
        end else if (r_reqf != SVC_NONE) begin
          w_state_nx = ST_OWN;
          w_grant_nx = r_reqf;
        end
      end
      ST_OWN: begin
        if (w_pop > 3'd1) begin
          w_state_nx = ST_CONFLICT;
          w_grant_nx = SVC_NONE;
        end else if ((finish & r_grant) != 4'b0000) begin
          w_state_nx = ST_DONE;
        end else if (r_reqf != r_grant) begin
          w_state_nx = ST_IDLE;
          w_grant_nx = SVC_NONE;
        end
      end
      ST_DONE: begin
        if (w_pop > 3'd1) begin
          w_state_nx = ST_CONFLICT;
          w_grant_nx = SVC_NONE;
        end else if (r_reqf != r_grant) begin
          w_state_nx = ST_IDLE;
          w_grant_nx = SVC_NONE;
        end
      end
      ST_CONFLICT: begin
        w_grant_nx = SVC_NONE;
        if (w_pop <= 3'd1) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_grant_nx = SVC_NONE;
      end
    endcase
`ifdef ALARM_PREEMPT_EN
    // Applied last so the alarm overrides every other transition.
    if (alarm_ring) begin
      w_state_nx = ST_PREEMPT;
      w_grant_nx = SVC4;
    end
`endif
  end

`ifndef ALARM_PREEMPT_EN
  logic w_unused_alarm;
  assign w_unused_alarm = alarm_ring;
`endif

  always_ff @(posedge clk_osc or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_grant <= SVC_NONE;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
    end
  end

  always_comb begin
    w_word     = '0;
    w_mask     = '0;
    w_blink_en = 1'b0;
    case (r_grant)
      SVC1: begin
        w_word     = num_bus[63:48];
        w_mask     = blink_mask[7:4];
        w_blink_en = 1'b1;
      end
      SVC2: begin
        w_word     = num_bus[47:32];
        w_mask     = blink_mask[3:0];
        w_blink_en = 1'b1;
      end
      SVC3: w_word = num_bus[31:16];
      SVC4: w_word = num_bus[15:0];
      default: w_word = '0;
    endcase
    if (r_state == ST_PREEMPT) begin
      w_blink_en = 1'b0;
    end
  end

  digit_scan #(
    .SCAN_W  (SCAN_W),
    .BLINK_W (BLINK_W)
  ) u_digit_scan (
    .clk_osc    (clk_osc),
    .reset      (reset),
    .i_active   (r_grant != SVC_NONE),
    .i_word     (w_word),
    .i_mask     (w_mask),
    .i_blink_en (w_blink_en),
    .o_anode    (anode),
    .o_digit    (digit)
  );

  assign grant    = r_grant;
  assign mode_led = ((r_state == ST_OWN) || (r_state == ST_PREEMPT)) ? r_grant : 4'b0000;
  assign conflict = (r_state == ST_CONFLICT);

endmodule

// File: tb/tb_service_display_arbiter.sv
// Directed self-checking bench for service_display_arbiter (small scan counter for speed).
module tb_service_display_arbiter;

  logic        clk_osc;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  finish;
  logic        alarm_ring;
  logic [63:0] num_bus;
  logic [7:0]  blink_mask;
  logic [3:0]  grant;
  logic [3:0]  anode;
  logic [3:0]  digit;
  logic [3:0]  mode_led;
  logic        conflict;

  int checks   = 0;
  int failures = 0;

  service_display_arbiter #(
    .SCAN_W   (4),
    .BLINK_W  (25),
    .STABLE_N (4)
  ) dut (
    .clk_osc    (clk_osc),
    .reset      (reset),
    .req        (req),
    .finish     (finish),
    .alarm_ring (alarm_ring),
    .num_bus    (num_bus),
    .blink_mask (blink_mask),
    .grant      (grant),
    .anode      (anode),
    .digit      (digit),
    .mode_led   (mode_led),
    .conflict   (conflict)
  );

  initial begin
    clk_osc = 1'b0;
    forever #5 clk_osc = ~clk_osc;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_osc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples one full 16-cycle scan; masked digits must never be lit, others exactly 4 cycles.
  task automatic scan_check(input string tag, input logic [15:0] word, input logic [3:0] mask);
    int cnt_i[4];
    int nblank;
    logic found;
    logic [3:0] exp_an;
    for (int i = 0; i < 4; i++) cnt_i[i] = 0;
    nblank = 0;
    for (int s = 0; s < 16; s++) begin
      if (anode === 4'b1111) begin
        nblank++;
      end else begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          exp_an = ~(4'b0001 << i);
          if (anode === exp_an) begin
            found = 1'b1;
            cnt_i[i]++;
            chk({tag, "_digit"}, 16'(digit), 16'(word[4*i +: 4]));
          end
        end
        chk({tag, "_anode_legal"}, 16'(found), 16'd1);
      end
      tick(1);
    end
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_count"}, 16'(cnt_i[i]), mask[i] ? 16'd0 : 16'd4);
    end
    chk({tag, "_blank_count"}, 16'(nblank), 16'(4 * $countones(mask)));
  endtask

  initial begin
    reset      = 1'b1;
    req        = 4'b0000;
    finish     = 4'b0000;
    alarm_ring = 1'b0;
    blink_mask = 8'h00;
    num_bus    = {16'h1234, 16'h5678, 16'hFA93, 16'h0009};
    #2 reset = 1'b0;
    tick(2);
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_anode", 16'(anode), 16'hF);
    chk("rst_digit", 16'(digit), 16'h0);
    chk("rst_mode_led", 16'(mode_led), 16'h0);
    chk("rst_conflict", 16'(conflict), 16'h0);
    reset = 1'b1;

    // svc1 owns after exactly 2+4+1 edges
    req = 4'b1000;
    tick(6);
    chk("t1_grant_early", 16'(grant), 16'h0);
    tick(1);
    chk("t1_grant", 16'(grant), 16'h8);
    chk("t1_mode_led", 16'(mode_led), 16'h8);
    chk("t1_conflict", 16'(conflict), 16'h0);
    tick(1);
    scan_check("t1_scan", 16'h1234, 4'b0000);

    // svc2 with digit 2 blinking (phase 0 while bcnt top bit is still low)
    blink_mask = 8'hF4;
    req = 4'b0100;
    tick(7);
    chk("t2_release", 16'(grant), 16'h0);
    tick(1);
    chk("t2_grant", 16'(grant), 16'h4);
    chk("t2_mode_led", 16'(mode_led), 16'h4);
    tick(1);
    scan_check("t2_scan", 16'h5678, 4'b0100);

    // release then conflict
    req = 4'b0000;
    tick(7);
    chk("t3_release", 16'(grant), 16'h0);
    chk("t3_release_led", 16'(mode_led), 16'h0);
    req = 4'b1010;
    tick(6);
    chk("t3_conflict_early", 16'(conflict), 16'h0);
    tick(1);
    chk("t3_conflict", 16'(conflict), 16'h1);
    chk("t3_conflict_grant", 16'(grant), 16'h0);
    chk("t3_conflict_led", 16'(mode_led), 16'h0);
    tick(1);
    chk("t3_conflict_anode", 16'(anode), 16'hF);
    chk("t3_conflict_digit", 16'(digit), 16'h0);
    blink_mask = 8'hFF;
    req = 4'b0010;
    tick(7);
    chk("t3_exit_conflict", 16'(conflict), 16'h0);
    chk("t3_exit_grant", 16'(grant), 16'h0);
    tick(1);
    chk("t3_svc3_grant", 16'(grant), 16'h2);
    chk("t3_svc3_led", 16'(mode_led), 16'h2);
    tick(1);
    scan_check("t3_scan", 16'hFA93, 4'b0000);

    // finish pulse -> DONE
    finish = 4'b0010;
    tick(1);
    finish = 4'b0000;
    chk("t4_done_led", 16'(mode_led), 16'h0);
    chk("t4_done_grant", 16'(grant), 16'h2);
    tick(3);
    chk("t4_done_hold", 16'(grant), 16'h2);
    blink_mask = 8'h00;
    req = 4'b0000;
    tick(6);
    chk("t4_done_still", 16'(grant), 16'h2);
    tick(1);
    chk("t4_idle_grant", 16'(grant), 16'h0);

    // alarm preemption
    req = 4'b1000;
    tick(7);
    chk("t5_own_svc1", 16'(grant), 16'h8);
    alarm_ring = 1'b1;
    tick(1);
`ifdef ALARM_PREEMPT_EN
    chk("t5_preempt_grant", 16'(grant), 16'h1);
    chk("t5_preempt_led", 16'(mode_led), 16'h1);
`else
    chk("t5_ignore_grant", 16'(grant), 16'h8);
    chk("t5_ignore_led", 16'(mode_led), 16'h8);
`endif
    alarm_ring = 1'b0;
    tick(2);
    chk("t5_back_grant", 16'(grant), 16'h8);
    chk("t5_back_led", 16'(mode_led), 16'h8);

    // asynchronous reset mid-scan
    tick(5);
    chk("t6_pre_grant", 16'(grant), 16'h8);
    #2 reset = 1'b0;
    #1;
    chk("t6_anode", 16'(anode), 16'hF);
    chk("t6_grant", 16'(grant), 16'h0);
    chk("t6_mode_led", 16'(mode_led), 16'h0);
    chk("t6_digit", 16'(digit), 16'h0);
    reset = 1'b1;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
